// File: rtl/csa_pkg.sv
// Shared types and elaboration helpers for the carry-save resolve slice.
package csa_pkg;

  typedef enum logic [1:0] {IDLE, ADD, DONE} csa_res_state_t;

  // Number of CHUNK-wide slices that make up a WIDTH-bit word.
  function automatic int unsigned nchunk(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

  // A word must split into whole chunks with no remainder.
  function automatic bit chunk_ok(input int unsigned width, input int unsigned chunk);
    return (chunk != 0) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

  // Chunk index width; a single-chunk build still keeps a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/csa_resolve_serial_if.sv
// Operand/result handshake bundle for csa_resolve_serial.
interface csa_resolve_serial_if #(
  parameter int unsigned WIDTH = 256
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;

  // Source of operands and sink of results (the surrounding datapath).
  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
  );

  // The resolver itself.
  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_cout
  );
endinterface

// File: rtl/csa_chunk_add.sv
// One CHUNK-bit slice of the serial carry-propagate add: a + b + cin.
module csa_chunk_add #(
  parameter int unsigned CHUNK = 64
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] total;

  // Plain ripple add; kept in its own module so a carry-select slice can drop in.
  always_comb begin
    total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  end

  assign sum  = total[CHUNK-1:0];
  assign cout = total[CHUNK];

endmodule

// File: rtl/csa_resolve_serial.sv
// Resolves a two-row carry-save result into one binary word, CHUNK bits per cycle.
module csa_resolve_serial
  import csa_pkg::*;
#(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned CHUNK = 64
) (
  input logic                 clk,
  input logic                 rst,
  csa_resolve_serial_if.slave bus
);

  localparam int unsigned NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int unsigned IDXW   = idx_width(NCHUNK);
  localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

  if (!chunk_ok(WIDTH, CHUNK)) begin : g_bad_chunk
    $error("csa_resolve_serial: WIDTH must be a non-zero multiple of CHUNK");
  end

  csa_res_state_t state;

  // Operands and result are viewed as arrays of chunks so the running index
  // selects a whole slice without a wide variable part-select.
  logic [NCHUNK-1:0][CHUNK-1:0] a_q;
  logic [NCHUNK-1:0][CHUNK-1:0] b_q;
  logic [NCHUNK-1:0][CHUNK-1:0] res_q;
  logic [IDXW-1:0]              idx;
  logic                         cy;
  logic                         cout_q;
  logic                         valid_q;

  logic [CHUNK-1:0] s_chunk;
  logic             c_next;

  csa_chunk_add #(.CHUNK(CHUNK)) u_chunk_add (
    .a    (a_q[idx]),
    .b    (b_q[idx]),
    .cin  (cy),
    .sum  (s_chunk),
    .cout (c_next)
  );

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = valid_q;
  assign bus.out_sum   = res_q;
  assign bus.out_cout  = cout_q;

  // Control FSM: accept operands, ripple one chunk per edge, hold result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      cy      <= 1'b0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q   <= bus.in_a;
            b_q   <= bus.in_b;
            idx   <= '0;
            cy    <= 1'b0;
            state <= ADD;
          end
        end
        ADD: begin
          res_q[idx] <= s_chunk;
          cy         <= c_next;
          if (idx == LAST) begin
            cout_q  <= c_next;
            valid_q <= 1'b1;
            state   <= DONE;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csa_resolve_serial.sv
// Directed and randomized checks of csa_resolve_serial in 4-chunk and 1-chunk builds.
module tb_csa_resolve_serial;

  localparam int unsigned W = 256;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  csa_resolve_serial_if #(.WIDTH(W)) bus0 ();
  csa_resolve_serial_if #(.WIDTH(W)) bus1 ();

  csa_resolve_serial #(.WIDTH(W), .CHUNK(64)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  csa_resolve_serial #(.WIDTH(W), .CHUNK(256)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int sel, input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    if (sel == 0) begin
      bus0.in_valid = v; bus0.in_a = a; bus0.in_b = b;
    end else begin
      bus1.in_valid = v; bus1.in_a = a; bus1.in_b = b;
    end
  endtask

  task automatic set_ordy(input int sel, input logic r);
    if (sel == 0) bus0.out_ready = r;
    else          bus1.out_ready = r;
  endtask

  function automatic logic get_rdy(input int sel);
    return (sel == 0) ? bus0.in_ready : bus1.in_ready;
  endfunction

  function automatic logic get_vld(input int sel);
    return (sel == 0) ? bus0.out_valid : bus1.out_valid;
  endfunction

  function automatic logic [W:0] get_res(input int sel);
    return (sel == 0) ? {bus0.out_cout, bus0.out_sum} : {bus1.out_cout, bus1.out_sum};
  endfunction

  function automatic logic [W-1:0] rnd_word();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Bounded wait for in_ready with in_valid already asserted; returns 1 on success.
  task automatic wait_ready(input int sel, input string tag, output bit ok);
    int n;
    n = 0;
    while (!get_rdy(sel) && n < 50) begin
      step();
      n++;
    end
    ok = get_rdy(sel);
    if (!ok) check({tag, "_accept_timeout"}, '0, (W+1)'(1));
  endtask

  // Full operation: offer, accept, wait for result, optional stall, compare, handshake.
  task automatic do_op(input int sel, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int unsigned stall, input int exp_lat, input bit chk_cy,
                       input string tag, input logic [W:0] exp);
    int n;
    bit ok;
    set_in(sel, 1'b1, a, b);
    wait_ready(sel, tag, ok);
    if (!ok) begin
      set_in(sel, 1'b0, '0, '0);
      return;
    end
    step();
    set_in(sel, 1'b0, '0, '0);
    n = 0;
    while (!get_vld(sel) && n < 50) begin
      step();
      n++;
      if (chk_cy && sel == 0) check({tag, "_cy"}, (W+1)'(dut0.cy), (W+1)'(1));
    end
    if (!get_vld(sel)) begin
      check({tag, "_result_timeout"}, '0, (W+1)'(1));
      return;
    end
    if (exp_lat >= 0) check({tag, "_lat"}, (W+1)'(n), (W+1)'(exp_lat));
    repeat (stall) step();
    check({tag, "_hold_vld"}, (W+1)'(get_vld(sel)), (W+1)'(1));
    check({tag, "_sum"}, get_res(sel), exp);
    set_ordy(sel, 1'b1);
    step();
    set_ordy(sel, 1'b0);
    check({tag, "_vld_drop"}, (W+1)'(get_vld(sel)), '0);
  endtask

  initial begin
    logic [W-1:0] ones, msb, low64, a1, b1, a2, b2, ra, rb;
    logic [W:0]   carry_only;
    bit ok;
    int n;

    ones  = '1;
    msb   = '0;
    msb[W-1] = 1'b1;
    low64 = W'(64'hFFFF_FFFF_FFFF_FFFF);
    carry_only = '0;
    carry_only[W] = 1'b1;

    // Reset with in_valid high on both: nothing may be accepted.
    rst = 1'b1;
    set_in(0, 1'b1, W'(1), W'(2));
    set_in(1, 1'b1, W'(1), W'(2));
    set_ordy(0, 1'b0);
    set_ordy(1, 1'b0);
    repeat (3) step();
    check("rst_rdy0", (W+1)'(get_rdy(0)), '0);
    check("rst_rdy1", (W+1)'(get_rdy(1)), '0);
    check("rst_vld0", (W+1)'(get_vld(0)), '0);
    check("rst_res0", get_res(0), '0);
    check("rst_res1", get_res(1), '0);
    rst = 1'b0;
    set_in(0, 1'b0, '0, '0);
    set_in(1, 1'b0, '0, '0);
    #1;
    check("post_rst_rdy0", (W+1)'(get_rdy(0)), (W+1)'(1));
    step();
    check("idle_rdy0", (W+1)'(get_rdy(0)), (W+1)'(1));
    check("idle_vld0", (W+1)'(get_vld(0)), '0);

    // 1: small add, 4-edge latency.
    do_op(0, W'(5), W'(7), 0, 4, 1'b0, "t1", (W+1)'(12));

    // 2: carry ripples through every chunk; carry register set after each ADD edge.
    do_op(0, ones, W'(1), 0, 4, 1'b1, "t2", carry_only);

    // 3: MSB-only carry out, then carry out of the low chunk into chunk 1.
    do_op(0, msb, msb, 0, 4, 1'b0, "t3a", carry_only);
    do_op(0, low64, low64, 1, 4, 1'b0, "t3b", (W+1)'(68'h1_FFFF_FFFF_FFFF_FFFE));

    // 4: backpressure in DONE while the next op waits with in_valid high.
    a1 = W'(100); b1 = W'(23); a2 = W'(1000); b2 = W'(1);
    set_in(0, 1'b1, a1, b1);
    wait_ready(0, "t4", ok);
    step();
    set_in(0, 1'b1, a2, b2);
    n = 0;
    while (!get_vld(0) && n < 50) begin
      step();
      n++;
    end
    check("t4_lat", (W+1)'(n), (W+1)'(4));
    for (int k = 0; k < 10; k++) begin
      check("t4_hold_sum", get_res(0), (W+1)'(123));
      check("t4_hold_vld", (W+1)'(get_vld(0)), (W+1)'(1));
      check("t4_hold_rdy", (W+1)'(get_rdy(0)), '0);
      step();
    end
    set_ordy(0, 1'b1);
    step();
    set_ordy(0, 1'b0);
    check("t4_rdy_after_hs", (W+1)'(get_rdy(0)), (W+1)'(1));
    check("t4_res_kept", get_res(0), (W+1)'(123));
    do_op(0, a2, b2, 0, 4, 1'b0, "t4b", (W+1)'(1001));

    // 5: reset pulse at the second ADD edge aborts the op.
    set_in(0, 1'b1, W'(9), W'(9));
    wait_ready(0, "t5", ok);
    step();
    set_in(0, 1'b0, '0, '0);
    step();
    rst = 1'b1;
    #1;
    check("t5_rdy_in_rst", (W+1)'(get_rdy(0)), '0);
    step();
    rst = 1'b0;
    #1;
    check("t5_rdy_after", (W+1)'(get_rdy(0)), (W+1)'(1));
    check("t5_vld_after", (W+1)'(get_vld(0)), '0);
    check("t5_res_cleared", get_res(0), '0);
    for (int k = 0; k < 6; k++) begin
      step();
      check("t5_no_emit", (W+1)'(get_vld(0)), '0);
    end
    do_op(0, W'(3), W'(4), 0, 4, 1'b0, "t5b", (W+1)'(7));

    // 6: single-chunk build, 1-edge latency.
    do_op(1, msb, msb, 0, 1, 1'b0, "t6", carry_only);
    do_op(1, ones, W'(1), 0, 1, 1'b0, "t6w", carry_only);

    // Randomized operands with random consumer stalls, alternating builds.
    for (int i = 0; i < 1000; i++) begin
      ra = rnd_word();
      rb = rnd_word();
      if (i % 11 == 0) ra = ones;
      do_op(i % 2, ra, rb, $urandom_range(0, 3), (i % 2 == 0) ? 4 : 1, 1'b0, "rnd",
            {1'b0, ra} + {1'b0, rb});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
